// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: per-axis mode descriptors for the supported
// modes and a helper that sums an axis into its total period.
package vga_timing_pkg;

  typedef struct packed {
    int visible;
    int front;
    int pulse;
    int back;
  } vga_axis_t;

  // 800x600@72
  localparam vga_axis_t SVGA_H = '{visible: 800, front: 56, pulse: 120, back: 64};
  localparam vga_axis_t SVGA_V = '{visible: 600, front: 37, pulse: 6,   back: 23};

  // 640x480@60
  localparam vga_axis_t VGA_H  = '{visible: 640, front: 16, pulse: 96,  back: 48};
  localparam vga_axis_t VGA_V  = '{visible: 480, front: 10, pulse: 2,   back: 33};

  function automatic int vga_total(input int visible, input int front,
                                   input int pulse, input int back);
    return visible + front + pulse + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus visible-region and sync
// decode. The same block serves the horizontal and vertical axes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 800,
  parameter int FRONT   = 56,
  parameter int PULSE   = 120,
  parameter int BACK    = 64,
  parameter bit POL     = 1'b1,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = vga_total(VISIBLE, FRONT, PULSE, BACK);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_C   = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + PULSE - 1);

  generate
    if (64'(TOTAL) > (64'd1 << CNT_W)) begin : g_bad_width
      $error("vga_axis_counter: axis total %0d does not fit in %0d bits", TOTAL, CNT_W);
    end
    if (FRONT == 0 || PULSE == 0 || BACK == 0) begin : g_bad_timing
      $error("vga_axis_counter: porch and pulse widths must be non-zero");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = inc & w_last;
  assign active = (r_cnt < VIS_C);
  assign sync   = ((r_cnt >= SYNC_LO) && (r_cnt <= SYNC_HI)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, syncs, display
// enable and line/frame strobes. Define VGA_TG_REG_OUT_EN to register every output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = SVGA_H.visible,
  parameter int H_FRONT   = SVGA_H.front,
  parameter int H_PULSE   = SVGA_H.pulse,
  parameter int H_BACK    = SVGA_H.back,
  parameter int V_VISIBLE = SVGA_V.visible,
  parameter int V_FRONT   = SVGA_V.front,
  parameter int V_PULSE   = SVGA_V.pulse,
  parameter int V_BACK    = SVGA_V.back,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             h_sync,
  output logic             v_sync,
  output logic             display_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_h_wrap, w_v_wrap;
  logic             w_h_active, w_v_active;
  logic             w_h_sync, w_v_sync;
  logic             w_v_inc;

  // The vertical axis steps only on the pixel that ends a line.
  assign w_v_inc = pix_en & w_h_wrap;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .PULSE(H_PULSE), .BACK(H_BACK),
    .POL(H_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk(clk), .rst(rst), .inc(pix_en),
    .cnt(w_h_cnt), .wrap(w_h_wrap), .active(w_h_active), .sync(w_h_sync)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .PULSE(V_PULSE), .BACK(V_BACK),
    .POL(V_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk(clk), .rst(rst), .inc(w_v_inc),
    .cnt(w_v_cnt), .wrap(w_v_wrap), .active(w_v_active), .sync(w_v_sync)
  );

`ifdef VGA_TG_REG_OUT_EN
  logic             r_h_sync, r_v_sync, r_display_en, r_line_end, r_frame_end;
  logic [CNT_W-1:0] r_x, r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_sync     <= ~H_POL;
      r_v_sync     <= ~V_POL;
      r_display_en <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_line_end   <= 1'b0;
      r_frame_end  <= 1'b0;
    end else begin
      r_h_sync     <= w_h_sync;
      r_v_sync     <= w_v_sync;
      r_display_en <= w_h_active & w_v_active;
      r_x          <= w_h_cnt;
      r_y          <= w_v_cnt;
      r_line_end   <= w_h_wrap;
      r_frame_end  <= w_h_wrap & w_v_wrap;
    end
  end

  assign h_sync     = r_h_sync;
  assign v_sync     = r_v_sync;
  assign display_en = r_display_en;
  assign x          = r_x;
  assign y          = r_y;
  assign line_end   = r_line_end;
  assign frame_end  = r_frame_end;
`else
  assign h_sync     = w_h_sync;
  assign v_sync     = w_v_sync;
  assign display_en = w_h_active & w_v_active;
  assign x          = w_h_cnt;
  assign y          = w_v_cnt;
  assign line_end   = w_h_wrap;
  assign frame_end  = w_h_wrap & w_v_wrap;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: horizontal and vertical position counters, sync pulses, display-enable, and line/frame strobes for an arbitrary mode. It sits between the pixel clock domain logic and the VGA pins and drives every pixel-producing block. It supersedes the horizontal-only line counter. It adds a vertical axis, programmable sync polarity, a pixel clock enable, exact-width sync pulses and pixel coordinates.

## Interface
- H_VISIBLE, 800: visible pixels per line
- H_FRONT, 56: horizontal front porch, pixels
- H_PULSE, 120: horizontal sync width, pixels
- H_BACK, 64: horizontal back porch, pixels
- V_VISIBLE, 600: visible lines per frame
- V_FRONT, 37: vertical front porch, lines
- V_PULSE, 6: vertical sync width, lines
- V_BACK, 23: vertical back porch, lines
- H_POL, 1: h_sync active level (1 = active-high)
- V_POL, 1: v_sync active level
- CNT_W, 12: counter and coordinate width
- clk input 1: pixel-domain clock
- rst input 1: synchronous, active-high reset
- pix_en input 1: pixel advance enable; counters move only when high
- h_sync output 1: horizontal sync at H_POL level during pulse
- v_sync output 1: vertical sync at V_POL level during pulse
- display_en output 1: high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE
- x output CNT_W: current h_cnt
- y output CNT_W: current v_cnt
- line_end output 1: one-clk strobe on the advancing cycle at h_cnt == H_TOTAL-1
- frame_end output 1: one-clk strobe on the advancing cycle at h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_PULSE+H_BACK (default 1040). V_TOTAL is computed the same way (default 666).
- Elaboration error if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if any porch or pulse is 0.
- Reset: h_cnt = 0, v_cnt = 0.
- When pix_en = 1: if h_cnt < H_TOTAL-1, then h_cnt increments. Otherwise h_cnt = 0 and v_cnt advances.
- v_cnt wraps to 0 from V_TOTAL-1 when h_cnt also wraps.
- When pix_en = 0: all counters hold, and line_end and frame_end stay low.
- h_sync is active for exactly H_PULSE pixels, at h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_PULSE-1]. It is inactive elsewhere.
- v_sync is active for exactly V_PULSE lines, for the whole of each line with v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_PULSE-1].
- Inactive sync level is ~POL.
- Decode is purely on counter values and is independent of pix_en. line_end and frame_end are qualified by pix_en.
- Reset asserted mid-frame: counters return to (0,0) on the next clk edge. No partial-line completion.

## Timing
- Without the configuration macro, all outputs are combinational decodes of the counters, which gives 0 latency.
- Reset values (combinational mode): x = 0, y = 0, display_en = 1, h_sync = ~H_POL, v_sync = ~V_POL, line_end = 0, frame_end = 0.
- line_end is coincident with the clk edge that wraps h_cnt. frame_end coincides with the edge that wraps both counters.
- With pix_en tied high, one line takes H_TOTAL clk cycles and one frame takes H_TOTAL*V_TOTAL cycles.

## Configuration
- VGA_TG_REG_OUT_EN defined: every output is registered, so all outputs are delayed by exactly one clk relative to the counters. This is glitch-free and suitable for driving pins directly. It has a one-clk delay regardless of pix_en.
  - Registered reset values: x = 0, y = 0, display_en = 0, h_sync = ~H_POL, v_sync = ~V_POL, line_end = 0, frame_end = 0.
  - The first clk after rst deasserts presents the decode of (0,0).
- VGA_TG_REG_OUT_EN undefined: outputs are combinational, as in Timing.

## Structure
- Package vga_timing_pkg holds:
  - localparam sets for supported modes: 800x600@72 (defaults above), 640x480@60 (640/16/96/48, 480/10/2/33).
  - a function computing the total from visible/front/pulse/back.
- Sub-module vga_axis_counter (parameters VISIBLE, FRONT, PULSE, BACK, POL, CNT_W; ports clk, rst, inc, cnt, wrap, active, sync).
  - Instantiated twice.
  - The horizontal instance's inc = pix_en.
  - The vertical instance's inc = pix_en & h_wrap.

## Test plan
- Reset, then pix_en = 1 for 1040 clk -> line_end exactly once, at h_cnt = 1039. y goes 0 -> 1. display_en high for 800 cycles per line.
- h_sync monitor -> active for exactly 120 cycles, starting at x = 856, last at x = 975. v_sync active for 6 lines, y = 637..642.
- Full frame (692640 clk) -> frame_end once, x and y both return to 0. Repeat with H_POL = 0, V_POL = 0 -> sync waveforms inverted.
- pix_en toggling 1,0,1,0 -> line length 2080 clk. Counters and strobes frozen on pix_en = 0 cycles.
- rst pulsed at (x = 500, y = 300) -> next cycle (0,0), display_en = 1 (combinational mode).
- VGA_TG_REG_OUT_EN build -> every output equals the combinational-build output delayed by one clk. display_en = 0 during reset.
